// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
// State encoding is fixed so that debug taps and the display firmware agree on it.
package stopwatch_pkg;

    localparam int COUNT_W_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LAP   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_HALT  = 3'd4
    } sw_state_e;

    // True in the states where time-base ticks reach the counter chain.
    function automatic logic is_counting(input sw_state_e st);
        return (st == ST_RUN) || (st == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_edge_detect.sv
// Rising-edge detector for one debounced, clk-synchronous button level.
// Resetting prev high suppresses a spurious edge from a button held through reset.
module edge_detect #(
    parameter logic RESET_PREV = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic edge_pulse
);

    logic prev_r;

    // Previous-cycle copy of the button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= RESET_PREV;
        end else begin
            prev_r <= level;
        end
    end

    assign edge_pulse = level & ~prev_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: gates the time-base tick into the counter chain,
// issues counter clears and freezes a lap value for the display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start_stop,
    input  logic               lap,
    input  logic               clear,
    input  logic               count_wrap,
    input  logic [COUNT_W-1:0] count_value,
    output logic               count_en,
    output logic               count_clr,
    output logic [COUNT_W-1:0] display_value,
    output logic               running,
    output logic               lap_active,
    output logic               overflow
);

    sw_state_e          state_r;
    logic [COUNT_W-1:0] lap_reg_r;
    logic               count_clr_r;
    logic               ss_edge_s;
    logic               lap_edge_s;
    logic               clr_edge_s;

    edge_detect #(.RESET_PREV(1'b1)) u_ss_edge (
        .clk        (clk),
        .rst        (rst),
        .level      (start_stop),
        .edge_pulse (ss_edge_s)
    );

    edge_detect #(.RESET_PREV(1'b1)) u_lap_edge (
        .clk        (clk),
        .rst        (rst),
        .level      (lap),
        .edge_pulse (lap_edge_s)
    );

    edge_detect #(.RESET_PREV(1'b1)) u_clr_edge (
        .clk        (clk),
        .rst        (rst),
        .level      (clear),
        .edge_pulse (clr_edge_s)
    );

    // Control FSM with lap capture and the one-cycle counter clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            lap_reg_r   <= {COUNT_W{1'b0}};
            count_clr_r <= 1'b0;
        end else begin
            count_clr_r <= 1'b0;
            if (clr_edge_s) begin
                state_r     <= ST_IDLE;
                lap_reg_r   <= {COUNT_W{1'b0}};
                count_clr_r <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE, ST_PAUSE: begin
                        if (ss_edge_s) begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        // A wrap outranks a coincident lap, so no capture happens then.
                        if (count_wrap) begin
                            state_r <= ST_HALT;
                        end else if (ss_edge_s) begin
                            state_r <= ST_PAUSE;
                        end else if (lap_edge_s) begin
                            state_r   <= ST_LAP;
                            lap_reg_r <= count_value;
                        end
                    end
                    ST_LAP: begin
                        if (count_wrap) begin
                            state_r <= ST_HALT;
                        end else if (ss_edge_s) begin
                            state_r <= ST_PAUSE;
                        end else if (lap_edge_s) begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_HALT: begin
                        state_r <= ST_HALT;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign count_clr     = count_clr_r;
    assign count_en      = tick & is_counting(state_r);
    assign display_value = (state_r == ST_LAP) ? lap_reg_r : count_value;
    assign running       = is_counting(state_r);
    assign lap_active    = (state_r == ST_LAP);
    assign overflow      = (state_r == ST_HALT);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a flag-based behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic        count_wrap = 1'b0;
    logic [63:0] count_value = 64'h0;
    logic        count_en, count_clr, running, lap_active, overflow;
    logic [63:0] display_value;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    stopwatch_ctrl #(.COUNT_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .start_stop    (start_stop),
        .lap           (lap),
        .clear         (clear),
        .count_wrap    (count_wrap),
        .count_value   (count_value),
        .count_en      (count_en),
        .count_clr     (count_clr),
        .display_value (display_value),
        .running       (running),
        .lap_active    (lap_active),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Model: the stopwatch is either counting, halted, or stopped (idle/pause alike).
    logic        m_counting, m_frozen, m_halted, m_clr;
    logic [63:0] m_lap_val;
    logic        m_prev_ss, m_prev_lap, m_prev_clr;
    wire         m_ss_e  = start_stop & ~m_prev_ss;
    wire         m_lap_e = lap & ~m_prev_lap;
    wire         m_clr_e = clear & ~m_prev_clr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_counting <= 1'b0; m_frozen <= 1'b0; m_halted <= 1'b0; m_clr <= 1'b0;
            m_lap_val  <= 64'h0;
            m_prev_ss  <= 1'b1; m_prev_lap <= 1'b1; m_prev_clr <= 1'b1;
        end else begin
            m_prev_ss  <= start_stop; m_prev_lap <= lap; m_prev_clr <= clear;
            m_clr      <= m_clr_e;
            if (m_clr_e) begin
                m_counting <= 1'b0; m_frozen <= 1'b0; m_halted <= 1'b0;
                m_lap_val  <= 64'h0;
            end else if (m_halted) begin
                m_halted <= 1'b1;
            end else if (m_counting) begin
                if (count_wrap) begin
                    m_halted <= 1'b1; m_counting <= 1'b0; m_frozen <= 1'b0;
                end else if (m_ss_e) begin
                    m_counting <= 1'b0; m_frozen <= 1'b0;
                end else if (m_lap_e) begin
                    m_frozen <= ~m_frozen;
                    if (!m_frozen) m_lap_val <= count_value;
                end
            end else if (m_ss_e) begin
                m_counting <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("count_en",   {63'h0, count_en},   {63'h0, tick & m_counting});
        chk("count_clr",  {63'h0, count_clr},  {63'h0, m_clr});
        chk("running",    {63'h0, running},    {63'h0, m_counting});
        chk("lap_active", {63'h0, lap_active}, {63'h0, m_frozen});
        chk("overflow",   {63'h0, overflow},   {63'h0, m_halted});
        chk("display",    display_value, m_frozen ? m_lap_val : count_value);
    end

    // Advance one cycle; inputs settle 1 time unit after the edge, tick every 4 cycles.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick = ((cyc % 4) == 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        while (!tick && k < 8) begin
            step();
            k++;
        end
        chk("tick_wait", {63'h0, tick}, 64'h1);
    endtask

    initial begin
        count_value = 64'h55;
        steps(2);
        #1;
        chk("rst_running", {63'h0, running}, 64'h0);
        chk("rst_display", display_value, 64'h55);
        chk("rst_clr",     {63'h0, count_clr}, 64'h0);
        rst = 1'b0;
        // Start at cycle 10.
        steps(8);
        start_stop = 1'b1;
        chk("pre_start_en", {63'h0, count_en}, 64'h0);
        step();
        start_stop = 1'b0;
        #1;
        chk("start_running", {63'h0, running}, 64'h1);
        wait_tick();
        #1;
        chk("start_en_tick", {63'h0, count_en}, 64'h1);
        // Lap capture and release.
        count_value = 64'h1234;
        lap = 1'b1;
        step();
        lap = 1'b0;
        count_value = 64'h1240;
        #1;
        chk("lap_freeze", display_value, 64'h1234);
        chk("lap_flag",   {63'h0, lap_active}, 64'h1);
        steps(2);
        count_value = 64'h1250;
        #1;
        chk("lap_hold", display_value, 64'h1234);
        lap = 1'b1;
        step();
        lap = 1'b0;
        #1;
        chk("lap_release", display_value, 64'h1250);
        chk("lap_off",     {63'h0, lap_active}, 64'h0);
        // Pause with a coincident tick.
        wait_tick();
        start_stop = 1'b1;
        #1;
        chk("stop_tick_counted", {63'h0, count_en}, 64'h1);
        step();
        start_stop = 1'b0;
        #1;
        chk("paused", {63'h0, running}, 64'h0);
        steps(6);
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        #1;
        chk("resumed", {63'h0, running}, 64'h1);
        // Priority: clear + start_stop + lap together while in LAP.
        count_value = 64'h777;
        lap = 1'b1;
        step();
        lap = 1'b0;
        step();
        chk("prio_in_lap", {63'h0, lap_active}, 64'h1);
        clear = 1'b1; start_stop = 1'b1; lap = 1'b1;
        step();
        #1;
        chk("prio_clr",     {63'h0, count_clr}, 64'h1);
        chk("prio_running", {63'h0, running}, 64'h0);
        chk("prio_display", display_value, 64'h777);
        step();
        #1;
        chk("prio_clr_once", {63'h0, count_clr}, 64'h0);
        clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        #1;
        chk("idle_clr_again", {63'h0, count_clr}, 64'h1);
        // Overflow: wrap coincident with lap edge in RUN.
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        count_value = 64'h999;
        count_wrap = 1'b1; lap = 1'b1;
        step();
        count_wrap = 1'b0; lap = 1'b0;
        count_value = 64'h0;
        #1;
        chk("ovf_flag",    {63'h0, overflow}, 64'h1);
        chk("ovf_no_cap",  display_value, 64'h0);
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        wait_tick();
        #1;
        chk("ovf_en_low",  {63'h0, count_en}, 64'h0);
        chk("ovf_stuck",   {63'h0, overflow}, 64'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        #1;
        chk("ovf_clr",     {63'h0, count_clr}, 64'h1);
        chk("ovf_cleared", {63'h0, overflow}, 64'h0);
        // Button held through reset.
        rst = 1'b1;
        start_stop = 1'b1;
        steps(2);
        rst = 1'b0;
        steps(3);
        chk("held_no_start", {63'h0, running}, 64'h0);
        start_stop = 1'b0;
        step();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        #1;
        chk("held_restart", {63'h0, running}, 64'h1);
        // Asynchronous mid-RUN reset.
        steps(2);
        rst = 1'b1;
        #1;
        chk("async_running", {63'h0, running}, 64'h0);
        chk("async_en",      {63'h0, count_en}, 64'h0);
        chk("async_clr",     {63'h0, count_clr}, 64'h0);
        steps(2);
        rst = 1'b0;
        steps(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch counting datapath. It takes the refresh/time-base tick from the clock divider and three debounced button levels. It gates the tick into the counter chain's enable, issues the counter clear, and freezes a lap (split) value for the display mux. It sits between the button debouncers, the divider and the BCD counter chain.

## Interface
Parameters:
- COUNT_W, 64, width of the counter chain value (16 nybbles).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle time-base pulse from the divider.
- start_stop  in  1  debounced button level, clk-synchronous.
- lap  in  1  debounced button level, clk-synchronous.
- clear  in  1  debounced button level, clk-synchronous.
- count_wrap  in  1  one-cycle pulse from the counter chain when it rolls over from its maximum.
- count_value  in  COUNT_W  live counter chain value.
- count_en  out  1  counter enable.
- count_clr  out  1  synchronous clear pulse to the counter chain.
- display_value  out  COUNT_W  value routed to the display mux.
- running  out  1  high in RUN or LAP.
- lap_active  out  1  high in LAP.
- overflow  out  1  high in HALT.

## Operation
- **Button edges:** each button level is registered once. An edge is `level & ~prev`. The prev registers reset to 1, so a button held through reset produces no edge.
- **Edge priority in the same cycle:** clear > count_wrap > start_stop > lap. Lower-priority events in that cycle are dropped.
- **States:** IDLE, RUN, LAP, PAUSE, HALT. Reset state is IDLE.
- **From any state, clear edge:** go to IDLE, assert count_clr, zero lap_reg.
- **IDLE:**
  - start_stop → RUN.
  - lap and count_wrap are ignored.
- **RUN:**
  - count_wrap → HALT.
  - start_stop → PAUSE.
  - lap → LAP, capturing count_value into lap_reg in the same edge.
- **LAP:**
  - count_wrap → HALT.
  - start_stop → PAUSE; the freeze is released.
  - lap → RUN; the freeze is released.
- **PAUSE:**
  - start_stop → RUN.
  - lap and count_wrap are ignored.
- **HALT:** only clear leaves it. The counter is held at its post-wrap value.
- **count_en:** `tick & (state==RUN | state==LAP)`, combinational from the registered state.
- **display_value:** lap_reg in LAP, otherwise count_value. This is a combinational mux.
- **Status flags:** running, lap_active and overflow are decoded from the registered state.

## Timing
- **Reset values:** state IDLE, lap_reg 0, count_clr 0, count_en 0, running/lap_active/overflow 0, display_value = count_value.
- **Edge to state change:** an edge detected in cycle n (level high in n, prev low) updates the state at the end of n. New outputs appear in n+1.
- **Tick coincident with a stop edge:** a tick in the same cycle as a stop edge is still counted, because the state is still RUN during that cycle.
- **count_clr:** registered. High exactly one cycle (n+1) after the clear-edge cycle n. It is asserted again on every clear edge, including when already in IDLE.
- **Lap capture:** lap_reg samples count_value at the end of the lap-edge cycle n. display_value shows it from n+1.
- **count_wrap handling:** in RUN/LAP a wrap takes effect at the end of its cycle, so count_en is low from n+1. A wrap coinciding with a lap edge goes to HALT with no capture.
- **Mid-operation reset:** rst asserted mid-operation forces IDLE immediately (asynchronous). It does not pulse count_clr; the counter chain has its own reset.

## Structure
- **stopwatch_pkg:** holds the state enum (3-bit encoding: IDLE=0, RUN=1, LAP=2, PAUSE=3, HALT=4) and the default COUNT_W constant.
- **edge_detect:** one sub-module with parameter RESET_PREV (default 1). It is instantiated three times, once per button.
- **Top level:** the FSM, lap_reg and the output decode stay in stopwatch_ctrl.

## Test plan
- **Reset and start:** rst pulse, then a start_stop level rise at cycle 10 with tick every 4 cycles → state RUN from cycle 11. count_en mirrors tick from cycle 11. No count_en before cycle 11.
- **Lap:** in RUN, lap rises with count_value=0x1234 → display_value=0x1234 next cycle and stays there while count_value advances. A second lap rise → display_value follows count_value again.
- **Pause/resume:** start_stop in RUN, with a tick in the same cycle → that tick still raises count_en. No count_en in PAUSE. start_stop again → RUN.
- **Priority:** clear, start_stop and lap rise in the same cycle while in LAP → IDLE, count_clr high exactly one cycle, lap_reg=0, running=0.
- **Overflow:** count_wrap in RUN coincident with a lap edge → HALT, overflow=1, count_en stays 0, start_stop ignored, lap_reg unchanged. A clear edge → IDLE plus count_clr.
- **Held button:** start_stop held high across rst deassertion → no transition until it is released and pressed again. rst asserted mid-RUN → outputs return to their reset values asynchronously.
